// File: rtl/ub_pack_pkg.sv
// rtl/ub_pack_pkg.sv - shared state type and default sizing for the UB write packer
package ub_pack_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_PACK,
        S_DRAIN,
        S_DONE
    } pack_state_t;

    localparam int DEF_LANES      = 4;
    localparam int DEF_ADDR_W     = 10;
    localparam int DEF_FIFO_DEPTH = 4;
    localparam int DEF_WORD_W     = 8 * DEF_LANES;

endpackage

// File: rtl/ub_word_fifo.sv
// rtl/ub_word_fifo.sv - first-word-fall-through word FIFO with simultaneous push/pop
module ub_word_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty,
    output logic             one_left
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             do_push;
    logic             do_pop;

    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign empty    = (count == '0);
    assign full     = (count == (PTR_W + 1)'(DEPTH));
    assign one_left = (count == (PTR_W + 1)'(1));
    assign head     = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (PTR_W + 1)'(1);
                2'b01:   count <= count - (PTR_W + 1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/ub_write_packer.sv
// rtl/ub_write_packer.sv - packs int8 results into UB words and writes them from a base address
module ub_write_packer
    import ub_pack_pkg::*;
#(
    parameter int LANES      = DEF_LANES,
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [ADDR_W-1:0]    base_addr,
    input  logic [ADDR_W:0]      num_words,
    input  logic                 flush,
    input  logic                 valid_in,
    input  logic [7:0]           data_in,
    output logic                 ub_wr_en,
    output logic [ADDR_W-1:0]    ub_wr_addr,
    output logic [8*LANES-1:0]   ub_wr_data,
    input  logic                 ub_wr_ready,
    output logic                 busy,
    output logic                 done,
    output logic                 overflow,
    output logic                 err_extra
);

    localparam int WORD_W = 8 * LANES;
    localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LANES - 1);

    pack_state_t       state;
    pack_state_t       state_next;
    logic [LANE_W-1:0] lane_cnt;
    logic [WORD_W-1:0] word_buf;
    logic [WORD_W-1:0] word_next;
    logic [ADDR_W:0]   remaining;
    logic              start_ok;
    logic              byte_in;
    logic              word_done;
    logic              flush_part;
    logic              push_req;
    logic              pop_fire;
    logic              fifo_full;
    logic              fifo_empty;
    logic              fifo_one_left;

    assign start_ok  = start && (state == S_IDLE);
    assign byte_in   = valid_in && (state == S_PACK);
    assign word_done = byte_in && (lane_cnt == LAST_LANE);
    // The same-cycle byte is packed before the flush, so a flush never pushes twice.
    assign flush_part = (state == S_PACK) && flush && !word_done
                        && ((lane_cnt != '0) || byte_in);
    assign push_req  = word_done || flush_part;
    assign pop_fire  = ub_wr_en && ub_wr_ready;
    assign ub_wr_en  = !fifo_empty;
    assign busy      = (state != S_IDLE);
    assign done      = (state == S_DONE);

    always_comb begin
        word_next = word_buf;
        if (byte_in) word_next[lane_cnt*8 +: 8] = data_in;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (start) state_next = (num_words == '0) ? S_DONE : S_PACK;
            S_PACK:  if ((word_done && remaining == (ADDR_W + 1)'(1)) || flush)
                         state_next = S_DRAIN;
            S_DRAIN: if (fifo_empty || (fifo_one_left && pop_fire))
                         state_next = S_DONE;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            lane_cnt   <= '0;
            word_buf   <= '0;
            remaining  <= '0;
            ub_wr_addr <= '0;
            overflow   <= 1'b0;
            err_extra  <= 1'b0;
        end else begin
            state <= state_next;
            if (start_ok) begin
                lane_cnt   <= '0;
                word_buf   <= '0;
                remaining  <= num_words;
                ub_wr_addr <= base_addr;
                overflow   <= 1'b0;
                err_extra  <= 1'b0;
            end else begin
                if (pop_fire) ub_wr_addr <= ub_wr_addr + ADDR_W'(1);
                if (push_req) begin
                    lane_cnt <= '0;
                    word_buf <= '0;
                end else if (byte_in) begin
                    lane_cnt <= lane_cnt + LANE_W'(1);
                    word_buf <= word_next;
                end
                if (word_done) remaining <= remaining - (ADDR_W + 1)'(1);
                if (push_req && fifo_full && !pop_fire) overflow <= 1'b1;
            end
            if (valid_in && state != S_PACK) err_extra <= 1'b1;
        end
    end

    ub_word_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (start_ok),
        .push      (push_req),
        .push_data (word_next),
        .pop       (pop_fire),
        .head      (ub_wr_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .one_left  (fifo_one_left)
    );

endmodule

// File: doc/ub_write_packer.md
# ub_write_packer

Downstream consumer of the post-accumulator activation/quantization pipeline. It packs the stream of quantized int8 results into LANES-byte words and writes them to consecutive unified-buffer addresses, starting from a programmed base. The upstream stage has no backpressure, so a small word FIFO absorbs UB write stalls, and overflow is flagged rather than stalled. Completion is signalled to the controller with a done pulse.

## Interface
- LANES, 4: int8 lanes per UB word; word width is 8*LANES.
- ADDR_W, 10: UB word-address width.
- FIFO_DEPTH, 4: word FIFO depth, power of two, ≥2.
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- start  in  1  single-cycle pulse; loads base_addr and num_words; ignored unless state is IDLE.
- base_addr  in  ADDR_W  first UB word address.
- num_words  in  ADDR_W+1  words to write, 0..2^ADDR_W.
- flush  in  1  ends the transfer early; zero-pads a partial word.
- valid_in  in  1  data_in valid, from the pipeline valid_out.
- data_in  in  8  signed int8 result, from the pipeline UB data output.
- ub_wr_en  out  1  write request.
- ub_wr_addr  out  ADDR_W  write address.
- ub_wr_data  out  8*LANES  packed word.
- ub_wr_ready  in  1  UB accepts the write this cycle.
- busy  out  1  state is not IDLE.
- done  out  1  one-cycle completion pulse.
- overflow  out  1  sticky; a word was dropped because the FIFO was full.
- err_extra  out  1  sticky; a byte arrived outside PACK.

## Operation
- States are IDLE, PACK, DRAIN, DONE.
- IDLE → PACK on start. Start loads the address counter from base_addr and the remaining-word counter from num_words, clears lane_cnt, overflow and err_extra, and empties the FIFO. If num_words=0, go IDLE → DONE instead.
- Packing in PACK:
  - Each valid_in writes data_in into lane lane_cnt, bits [8k+7:8k], byte 0 in the LSBs. lane_cnt then increments.
  - When lane LANES-1 is written, the word is complete. Push it to the FIFO, reset lane_cnt to 0, and decrement remaining.
- If the FIFO is full at push time, drop the word and set overflow. The word still counts toward remaining.
- PACK → DRAIN when remaining reaches 0, or on flush.
- Flush with lane_cnt>0 pushes the partial word with unwritten lanes zero. If valid_in and flush occur in the same cycle, the byte is packed first, then the flush applies. Flush with lane_cnt=0 pushes nothing.
- DRAIN → DONE when the FIFO is empty and no write is pending.
- DONE lasts one cycle, drives done=1, then → IDLE.
- valid_in in IDLE, DRAIN or DONE: drop the byte and set err_extra.
- Write port:
  - ub_wr_en = FIFO non-empty; ub_wr_data = FIFO head.
  - A transfer occurs when ub_wr_en && ub_wr_ready; it pops the FIFO and increments ub_wr_addr modulo 2^ADDR_W.
  - A push and a pop in the same cycle is legal even when the FIFO is full (no overflow in that case).
- flush and start are ignored in states where they do not apply.

## Timing
- Reset values: ub_wr_en 0, ub_wr_addr 0, ub_wr_data 0, busy 0, done 0, overflow 0, err_extra 0, state IDLE, FIFO empty, lane_cnt 0.
- Reset during any state returns all of the above in the next cycle. Pending words are discarded and no further writes are issued.
- Latency: a word completed by the byte at cycle t gives ub_wr_en=1 at t+1 with that word's data and address.
- With ready held high, throughput is one word per cycle.
- done asserts the cycle after the final accepted transfer, or the cycle after start when num_words=0.
- busy rises the cycle after start and falls in the same cycle done falls.

## Structure
- Shared package ub_pack_pkg holds:
  - the state enum typedef;
  - the default constants LANES, ADDR_W and FIFO_DEPTH;
  - a localparam for word width.
- Sub-module ub_word_fifo: synchronous FIFO with first-word-fall-through, full/empty flags, and simultaneous push/pop.

## Test plan
- Basic transfer: base_addr=0x010, num_words=2, bytes 01..08 on consecutive cycles, ready=1 → writes (0x010, 0x04030201) and (0x011, 0x08070605), done one cycle after the second write, overflow=0.
- Backpressure within capacity: ready=0 for 20 cycles, num_words=3, 12 bytes → no writes while ready is low, overflow=0; once ready=1, three writes at base..base+2 in order, then done.
- Overflow: FIFO_DEPTH=4, ready=0, num_words=6, 24 bytes → overflow=1; only words 1–4 are written after ready rises; done follows the fourth write.
- Address wrap and flush: base_addr=0x3FF, num_words=2, bytes 11,22,33,44,55 then flush → writes (0x3FF, 0x44332211) and (0x000, 0x00000055), then done.
- Stray bytes and restart: valid_in in IDLE → err_extra=1 and nothing written; a later start clears err_extra.
- Reset mid-operation: rst_n=0 while the FIFO holds words → next cycle all outputs are at reset values and no ub_wr_en thereafter; a new start then operates normally.
